// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - classifies a debounced button into press/release/short/long/double/repeat pulses
module button_event_decoder #(
  parameter int LONG_CYCLES   = 50000000,
  parameter int GAP_CYCLES    = 12500000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int CNT_W         = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic repeat_pulse,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PRESSED     = 3'd1,
    LONG_HELD   = 3'd2,
    GAP_WAIT    = 3'd3,
    SECOND_HELD = 3'd4
  } state_e;

  // The counter holds (edges since entering the state) - 1, so a match on
  // N-1 fires exactly N edges after the entry edge.
  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_TERM  = CNT_W'(REPEAT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q, btn_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             double_q, double_d;
  logic             repeat_q, repeat_d;
  logic             busy_q, busy_d;
  logic             rise, fall;

  assign rise = btn_level & ~btn_q;
  assign fall = ~btn_level & btn_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    btn_d     = btn_level;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    double_d  = 1'b0;
    repeat_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESSED;
          press_d = 1'b1;
          cnt_d   = '0;
        end
      end
      PRESSED: begin
        // A release on the very edge that would reach the long threshold wins.
        if (fall) begin
          state_d   = GAP_WAIT;
          release_d = 1'b1;
          cnt_d     = '0;
        end else if (cnt_q == LONG_TERM) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LONG_HELD: begin
        if (fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
          cnt_d     = '0;
        end else if (cnt_q == REP_TERM) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP_WAIT: begin
        // A second press on the last gap edge still counts as a double.
        if (rise) begin
          state_d  = SECOND_HELD;
          press_d  = 1'b1;
          double_d = 1'b1;
          cnt_d    = '0;
        end else if (cnt_q == GAP_TERM) begin
          state_d = IDLE;
          short_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SECOND_HELD: begin
        if (fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
          cnt_d     = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      btn_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      double_q  <= 1'b0;
      repeat_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_q     <= btn_d;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      long_q    <= long_d;
      double_q  <= double_d;
      repeat_q  <= repeat_d;
      busy_q    <= busy_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_press   = short_q;
  assign long_press    = long_q;
  assign double_press  = double_q;
  assign repeat_pulse  = repeat_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - scoreboard bench for button_event_decoder (LONG=8, GAP=4, REPEAT=3)
module tb_button_event_decoder;

  logic clk = 1'b0;
  logic reset;
  logic btn_level;
  logic press_pulse, release_pulse, short_press, long_press, double_press, repeat_pulse, busy;

  button_event_decoder #(
    .LONG_CYCLES(8),
    .GAP_CYCLES(4),
    .REPEAT_CYCLES(3),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .short_press(short_press),
    .long_press(long_press),
    .double_press(double_press),
    .repeat_pulse(repeat_pulse),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse vector order: {press, release, short, long, double, repeat}
  localparam logic [5:0] P  = 6'b100000;
  localparam logic [5:0] RL = 6'b010000;
  localparam logic [5:0] SH = 6'b001000;
  localparam logic [5:0] LG = 6'b000100;
  localparam logic [5:0] DB = 6'b000010;
  localparam logic [5:0] RP = 6'b000001;
  localparam logic [5:0] NONE = 6'b000000;

  typedef struct {
    int         e;
    logic [5:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Drive a level for one edge; v is the pulse set expected right after that edge.
  task automatic drv(input logic lvl, input logic [5:0] v);
    exp_t x;
    btn_level = lvl;
    @(posedge clk);
    #1;
    if (v != NONE) begin
      x.e = edge_cnt;
      x.v = v;
      exp_q.push_back(x);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, NONE);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    logic [5:0] v;
    exp_t       x;
    v = {press_pulse, release_pulse, short_press, long_press, double_press, repeat_pulse};
    if (v != NONE) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse edge=%0d got=%b want=none", edge_cnt, v);
      end else begin
        x = exp_q.pop_front();
        if (x.e != edge_cnt || x.v != v) begin
          errors++;
          $display("FAIL pulse_match got edge=%0d vec=%b want edge=%0d vec=%b", edge_cnt, v, x.e, x.v);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    btn_level = 1'b0;
    drv(1'b0, NONE);
    drv(1'b0, NONE);
    chk("reset_outputs", int'({press_pulse, release_pulse, short_press, long_press, double_press, repeat_pulse, busy}), 0);
    reset = 1'b0;
    idle(2);

    // Short press: 3 high edges, short 4 edges after the fall edge
    drv(1'b1, P);
    chk("busy_pressed", int'(busy), 1);
    drv(1'b1, NONE);
    drv(1'b1, NONE);
    drv(1'b0, RL);
    idle(3);
    chk("busy_gap", int'(busy), 1);
    drv(1'b0, SH);
    chk("busy_after_short", int'(busy), 0);
    idle(6);

    // Long hold of 20 edges: long at +8, repeats every 3 after, release on edge 20
    drv(1'b1, P);
    for (int i = 1; i < 8; i++) drv(1'b1, NONE);
    drv(1'b1, LG);
    for (int i = 1; i <= 11; i++) drv(1'b1, (i % 3 == 0) ? RP : NONE);
    chk("busy_long_held", int'(busy), 1);
    drv(1'b0, RL);
    chk("busy_after_long", int'(busy), 0);
    idle(8);

    // Double press: press 2, low 2, press 2
    drv(1'b1, P);
    drv(1'b1, NONE);
    drv(1'b0, RL);
    drv(1'b0, NONE);
    drv(1'b1, P | DB);
    drv(1'b1, NONE);
    drv(1'b0, RL);
    chk("busy_after_double", int'(busy), 0);
    idle(8);

    // Boundary: fall exactly on the long threshold edge
    drv(1'b1, P);
    for (int i = 1; i < 8; i++) drv(1'b1, NONE);
    drv(1'b0, RL);
    idle(3);
    drv(1'b0, SH);
    idle(4);

    // Boundary: second press exactly on the last gap edge
    drv(1'b1, P);
    drv(1'b0, RL);
    idle(3);
    drv(1'b1, P | DB);
    drv(1'b1, NONE);
    drv(1'b0, RL);
    idle(8);

    // Reset during gap wait with the button held through reset release
    drv(1'b1, P);
    drv(1'b0, RL);
    drv(1'b0, NONE);
    reset = 1'b1;
    drv(1'b1, NONE);
    chk("reset_mid_outputs_a", int'({press_pulse, release_pulse, short_press, long_press, double_press, repeat_pulse, busy}), 0);
    drv(1'b1, NONE);
    chk("reset_mid_outputs_b", int'({press_pulse, release_pulse, short_press, long_press, double_press, repeat_pulse, busy}), 0);
    drv(1'b1, NONE);
    chk("reset_mid_outputs_c", int'({press_pulse, release_pulse, short_press, long_press, double_press, repeat_pulse, busy}), 0);
    reset = 1'b0;
    drv(1'b1, P);
    chk("busy_after_reset_press", int'(busy), 1);
    drv(1'b1, NONE);
    drv(1'b0, RL);
    idle(3);
    drv(1'b0, SH);
    idle(6);

    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
